// File: rtl/poly_ram_seq_pkg.sv
//==============================================================================
// Module   : poly_ram_seq_pkg
// Brief    : Shared state encoding and sizing helpers for the polynomial RAM sequencer.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

`ifndef COMMON_BRAM_DELAY
`define COMMON_BRAM_DELAY 2
`endif

package poly_ram_seq_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_FULL  = 2'd2,
      ST_DRAIN = 2'd3
   } seq_state_t;

   localparam int DEF_COE_WIDTH     = 35;
   localparam int DEF_ADDR_WIDTH    = 9;
   localparam int DEF_NUM_BASE_BANK = 8;
   localparam int DEF_RD_LAT        = `COMMON_BRAM_DELAY;

   localparam int N_ROWS     = 1 << DEF_ADDR_WIDTH;
   localparam int FIFO_DEPTH = DEF_RD_LAT + 2;

   // Two slots beyond the read latency keep a full-rate stream under credit flow control.
   function automatic int fifo_depth(input int rd_lat);
      return rd_lat + 2;
   endfunction

endpackage

`default_nettype wire

// File: rtl/poly_ram_seq_skid.sv
//==============================================================================
// Module   : poly_ram_seq_skid
// Brief    : Small synchronous FIFO holding returned RAM rows plus their last tag.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module poly_ram_seq_skid #(
   parameter int WIDTH = 281,
   parameter int DEPTH = 4,
   parameter int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             empty,
   output logic [CNT_W-1:0] count
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [IDX_W-1:0] r_wr_idx;
   logic [IDX_W-1:0] r_rd_idx;
   logic [CNT_W-1:0] r_count;

   // Storage carries no reset; validity is tracked by r_count alone.
   always_ff @(posedge clk) begin
      if (push) begin
         r_mem[r_wr_idx] <= push_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_wr_idx <= '0;
         r_rd_idx <= '0;
         r_count  <= '0;
      end else begin
         if (push) begin
            r_wr_idx <= (r_wr_idx == LAST_IDX) ? '0 : r_wr_idx + IDX_W'(1);
         end
         if (pop) begin
            r_rd_idx <= (r_rd_idx == LAST_IDX) ? '0 : r_rd_idx + IDX_W'(1);
         end
         case ({push, pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   assign head  = r_mem[r_rd_idx];
   assign empty = (r_count == '0);
   assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/poly_ram_seq.sv
//==============================================================================
// Module   : poly_ram_seq
// Brief    : Loads a polynomial into a multi-bank RAM row by row, then streams it back in order.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module poly_ram_seq
   import poly_ram_seq_pkg::*;
#(
   parameter int COE_WIDTH     = DEF_COE_WIDTH,
   parameter int ADDR_WIDTH    = DEF_ADDR_WIDTH,
   parameter int NUM_BASE_BANK = DEF_NUM_BASE_BANK,
   parameter int RD_LAT        = DEF_RD_LAT
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              load_start,
   input  logic                              drain_start,
   input  logic                              in_valid,
   output logic                              in_ready,
   input  logic [COE_WIDTH*NUM_BASE_BANK-1:0]  in_data,
   output logic                              out_valid,
   input  logic                              out_ready,
   output logic [COE_WIDTH*NUM_BASE_BANK-1:0]  out_data,
   output logic                              out_last,
   output logic                              loaded,
   output logic                              busy,
   output logic [NUM_BASE_BANK-1:0]            ram_wea,
   output logic [ADDR_WIDTH*NUM_BASE_BANK-1:0] ram_addra,
   output logic [COE_WIDTH*NUM_BASE_BANK-1:0]  ram_dina,
   output logic [ADDR_WIDTH*NUM_BASE_BANK-1:0] ram_addrb,
   input  logic [COE_WIDTH*NUM_BASE_BANK-1:0]  ram_doutb
);

   localparam int ROW_W = COE_WIDTH * NUM_BASE_BANK;
   localparam int DEPTH = fifo_depth(RD_LAT);
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int OCC_W = CNT_W + 1;
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};

   seq_state_t r_state;
   seq_state_t w_state_nxt;

   logic [ADDR_WIDTH-1:0] r_wr_ptr;
   logic [ADDR_WIDTH-1:0] r_rd_ptr;
   logic [ADDR_WIDTH-1:0] r_addrb;
   logic                  r_rd_done;
   logic                  r_loaded;
   logic [RD_LAT-1:0]     r_vld_sr;
   logic [RD_LAT-1:0]     r_last_sr;

   logic             w_in_hs;
   logic             w_issue;
   logic             w_pop;
   logic             w_fifo_empty;
   logic [CNT_W-1:0] w_fifo_count;
   logic [OCC_W-1:0] w_inflight;
   logic [OCC_W-1:0] w_occupancy;
   logic [ROW_W:0]   w_fifo_head;
   logic             w_enter_load;
   logic             w_enter_drain;

   assign in_ready = (r_state == ST_LOAD);
   assign w_in_hs  = in_valid & in_ready;
   assign busy     = (r_state != ST_IDLE);
   assign loaded   = r_loaded;

   // Reads already issued count against FIFO space, so a returning row always has a slot.
   always_comb begin
      w_inflight = '0;
      for (int i = 0; i < RD_LAT; i++) begin
         w_inflight = w_inflight + {{CNT_W{1'b0}}, r_vld_sr[i]};
      end
   end

   assign w_occupancy = w_inflight + {1'b0, w_fifo_count};
   assign w_issue     = (r_state == ST_DRAIN) && !r_rd_done && (w_occupancy < OCC_W'(DEPTH));
   assign out_valid   = !w_fifo_empty;
   assign w_pop       = out_valid & out_ready;
   assign out_data    = w_fifo_head[ROW_W-1:0];
   assign out_last    = out_valid & w_fifo_head[ROW_W];

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         ST_IDLE: begin
            if (load_start) begin
               w_state_nxt = ST_LOAD;
            end else if (drain_start && r_loaded) begin
               w_state_nxt = ST_DRAIN;
            end
         end
         ST_LOAD: begin
            if (w_in_hs && (r_wr_ptr == LAST_ADDR)) begin
               w_state_nxt = ST_FULL;
            end
         end
         ST_FULL: begin
            if (load_start) begin
               w_state_nxt = ST_LOAD;
            end else if (drain_start) begin
               w_state_nxt = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (w_pop && w_fifo_head[ROW_W]) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   assign w_enter_load  = (r_state != ST_LOAD) && (w_state_nxt == ST_LOAD);
   assign w_enter_drain = (r_state != ST_DRAIN) && (w_state_nxt == ST_DRAIN);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state   <= ST_IDLE;
         r_wr_ptr  <= '0;
         r_rd_ptr  <= '0;
         r_addrb   <= '0;
         r_rd_done <= 1'b0;
         r_loaded  <= 1'b0;
         r_vld_sr  <= '0;
         r_last_sr <= '0;
      end else begin
         r_state <= w_state_nxt;

         if (w_enter_load) begin
            r_wr_ptr <= '0;
            r_loaded <= 1'b0;
         end else if (w_in_hs) begin
            r_wr_ptr <= r_wr_ptr + ADDR_WIDTH'(1);
            if (r_wr_ptr == LAST_ADDR) begin
               r_loaded <= 1'b1;
            end
         end else if (w_pop && w_fifo_head[ROW_W]) begin
            r_loaded <= 1'b0;
         end

         if (w_enter_drain) begin
            r_rd_ptr  <= '0;
            r_rd_done <= 1'b0;
         end else if (w_issue) begin
            r_rd_ptr <= r_rd_ptr + ADDR_WIDTH'(1);
            r_addrb  <= r_rd_ptr;
            if (r_rd_ptr == LAST_ADDR) begin
               r_rd_done <= 1'b1;
            end
         end

         for (int i = RD_LAT - 1; i > 0; i--) begin
            r_vld_sr[i]  <= r_vld_sr[i-1];
            r_last_sr[i] <= r_last_sr[i-1];
         end
         r_vld_sr[0]  <= w_issue;
         r_last_sr[0] <= w_issue && (r_rd_ptr == LAST_ADDR);
      end
   end

   assign ram_wea   = {NUM_BASE_BANK{w_in_hs}};
   assign ram_addra = w_in_hs ? {NUM_BASE_BANK{r_wr_ptr}} : '0;
   assign ram_dina  = w_in_hs ? in_data : '0;
   // Address is presented in the issue cycle and held afterwards.
   assign ram_addrb = {NUM_BASE_BANK{w_issue ? r_rd_ptr : r_addrb}};

   poly_ram_seq_skid #(
      .WIDTH (ROW_W + 1),
      .DEPTH (DEPTH),
      .CNT_W (CNT_W)
   ) u_skid (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (r_vld_sr[RD_LAT-1]),
      .push_data ({r_last_sr[RD_LAT-1], ram_doutb}),
      .pop       (w_pop),
      .head      (w_fifo_head),
      .empty     (w_fifo_empty),
      .count     (w_fifo_count)
   );

endmodule

`default_nettype wire

// File: tb/tb_poly_ram_seq.sv
//==============================================================================
// Module   : tb_poly_ram_seq
// Brief    : Self-checking bench: RAM model, row scoreboard and randomized flow control.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_poly_ram_seq;
   import poly_ram_seq_pkg::*;

   localparam int COE_W  = DEF_COE_WIDTH;
   localparam int AW     = DEF_ADDR_WIDTH;
   localparam int NB     = DEF_NUM_BASE_BANK;
   localparam int RD_LAT = DEF_RD_LAT;
   localparam int ROWS   = N_ROWS;
   localparam int ROW_W  = COE_W * NB;

   logic                clk = 1'b0;
   logic                rst_n;
   logic                load_start, drain_start;
   logic                in_valid, in_ready;
   logic [ROW_W-1:0]    in_data;
   logic                out_valid, out_ready, out_last;
   logic [ROW_W-1:0]    out_data;
   logic                loaded, busy;
   logic [NB-1:0]       ram_wea;
   logic [AW*NB-1:0]    ram_addra, ram_addrb;
   logic [ROW_W-1:0]    ram_dina, ram_doutb;

   int n_checks = 0;
   int n_fail   = 0;

   logic [ROW_W-1:0] exp_rows [ROWS];

   always #5 clk = ~clk;

   poly_ram_seq #(
      .COE_WIDTH     (COE_W),
      .ADDR_WIDTH    (AW),
      .NUM_BASE_BANK (NB),
      .RD_LAT        (RD_LAT)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .load_start  (load_start),
      .drain_start (drain_start),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_data     (in_data),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .out_last    (out_last),
      .loaded      (loaded),
      .busy        (busy),
      .ram_wea     (ram_wea),
      .ram_addra   (ram_addra),
      .ram_dina    (ram_dina),
      .ram_addrb   (ram_addrb),
      .ram_doutb   (ram_doutb)
   );

   // Per-bank memory with read-first behaviour and an RD_LAT-stage output pipe.
   logic [COE_W-1:0] mem [NB][ROWS];
   logic [ROW_W-1:0] rd_pipe [RD_LAT];

   always @(posedge clk) begin
      for (int b = 0; b < NB; b++) begin
         if (ram_wea[b]) mem[b][ram_addra[b*AW +: AW]] <= ram_dina[b*COE_W +: COE_W];
         rd_pipe[0][b*COE_W +: COE_W] <= mem[b][ram_addrb[b*AW +: AW]];
      end
      for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
   end
   assign ram_doutb = rd_pipe[RD_LAT-1];

   task automatic check_eq(input string tag, input logic [ROW_W-1:0] got, input logic [ROW_W-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [ROW_W-1:0] make_row(input int k, input bit pattern);
      logic [ROW_W-1:0] r;
      r = '0;
      for (int b = 0; b < NB; b++) begin
         if (pattern) r[b*COE_W +: COE_W] = COE_W'(k * NB + b);
         else         r[b*COE_W +: COE_W] = COE_W'({$urandom, $urandom});
      end
      return r;
   endfunction

   function automatic logic [AW*NB-1:0] rep_addr(input int k);
      logic [AW-1:0] a;
      a = AW'(k);
      return {NB{a}};
   endfunction

   task automatic do_load(input int gap_pct, input bit pattern, input bit both);
      int k = 0;
      int guard = 0;
      bit acc;
      logic [ROW_W-1:0] row;
      load_start  = 1'b1;
      drain_start = both;
      tick();
      load_start  = 1'b0;
      drain_start = 1'b0;
      check_eq("load_entry_ready", ROW_W'(in_ready), ROW_W'(1));
      check_eq("load_entry_loaded", ROW_W'(loaded), ROW_W'(0));
      while (k < ROWS && guard < 20000) begin
         row        = make_row(k, pattern);
         in_data    = row;
         in_valid   = ($urandom_range(99) >= gap_pct);
         load_start = (k == 100);
         drain_start = (k == 101);
         acc = 1'b0;
         @(negedge clk);
         if (in_valid && in_ready) begin
            check_eq("wea_hs", ROW_W'(ram_wea), ROW_W'({NB{1'b1}}));
            check_eq("addra_hs", ROW_W'(ram_addra), ROW_W'(rep_addr(k)));
            check_eq("dina_hs", ram_dina, row);
            exp_rows[k] = row;
            acc = 1'b1;
         end else begin
            check_eq("wea_idle", ROW_W'(ram_wea), ROW_W'(0));
         end
         tick();
         if (acc) k++;
         guard++;
      end
      in_valid    = 1'b0;
      load_start  = 1'b0;
      drain_start = 1'b0;
      check_eq("load_count", ROW_W'(k), ROW_W'(ROWS));
      check_eq("full_ready", ROW_W'(in_ready), ROW_W'(0));
      check_eq("full_loaded", ROW_W'(loaded), ROW_W'(1));
      check_eq("full_busy", ROW_W'(busy), ROW_W'(1));
   endtask

   task automatic do_drain(input int stall_pct, input int abort_at);
      int idx = 0;
      int guard = 0;
      int cyc = 0;
      bit held = 1'b0;
      logic [ROW_W-1:0] held_data = '0;
      check_eq("pre_drain_loaded", ROW_W'(loaded), ROW_W'(1));
      out_ready   = 1'b1;
      drain_start = 1'b1;
      tick();
      drain_start = 1'b0;
      while (!out_valid && cyc < 50) begin
         tick();
         cyc++;
      end
      check_eq("first_latency", ROW_W'(cyc), ROW_W'(RD_LAT + 1));
      while (idx < ROWS && guard < 20000) begin
         if (idx == abort_at) begin
            out_ready = 1'b0;
            rst_n     = 1'b0;
            tick();
            rst_n     = 1'b1;
            check_eq("abort_valid", ROW_W'(out_valid), ROW_W'(0));
            check_eq("abort_busy", ROW_W'(busy), ROW_W'(0));
            check_eq("abort_loaded", ROW_W'(loaded), ROW_W'(0));
            return;
         end
         out_ready = ($urandom_range(99) >= stall_pct);
         @(negedge clk);
         if (held) begin
            check_eq("stall_valid", ROW_W'(out_valid), ROW_W'(1));
            check_eq("stall_data", out_data, held_data);
         end
         held = 1'b0;
         if (out_valid) begin
            if (out_ready) begin
               check_eq("row_data", out_data, exp_rows[idx]);
               check_eq("row_last", ROW_W'(out_last), ROW_W'(idx == ROWS - 1));
               idx++;
            end else begin
               held      = 1'b1;
               held_data = out_data;
            end
         end
         tick();
         guard++;
      end
      out_ready = 1'b0;
      check_eq("drain_count", ROW_W'(idx), ROW_W'(ROWS));
      check_eq("post_drain_busy", ROW_W'(busy), ROW_W'(0));
      check_eq("post_drain_loaded", ROW_W'(loaded), ROW_W'(0));
      check_eq("post_drain_valid", ROW_W'(out_valid), ROW_W'(0));
   endtask

   initial begin
      rst_n       = 1'b0;
      load_start  = 1'b0;
      drain_start = 1'b0;
      in_valid    = 1'b0;
      in_data     = '0;
      out_ready   = 1'b0;
      repeat (3) tick();
      check_eq("rst_in_ready", ROW_W'(in_ready), ROW_W'(0));
      check_eq("rst_out_valid", ROW_W'(out_valid), ROW_W'(0));
      check_eq("rst_out_last", ROW_W'(out_last), ROW_W'(0));
      check_eq("rst_loaded", ROW_W'(loaded), ROW_W'(0));
      check_eq("rst_busy", ROW_W'(busy), ROW_W'(0));
      check_eq("rst_wea", ROW_W'(ram_wea), ROW_W'(0));
      check_eq("rst_addra", ROW_W'(ram_addra), ROW_W'(0));
      check_eq("rst_addrb", ROW_W'(ram_addrb), ROW_W'(0));
      check_eq("rst_dina", ram_dina, ROW_W'(0));
      rst_n = 1'b1;
      tick();

      // Drain request with nothing loaded must be ignored.
      drain_start = 1'b1;
      tick();
      drain_start = 1'b0;
      check_eq("ign_drain_busy", ROW_W'(busy), ROW_W'(0));
      tick();
      check_eq("ign_drain_busy2", ROW_W'(busy), ROW_W'(0));
      check_eq("ign_drain_valid", ROW_W'(out_valid), ROW_W'(0));

      do_load(0, 1'b1, 1'b0);
      do_drain(0, -1);

      do_load(50, 1'b0, 1'b0);
      // Simultaneous start from FULL: load takes priority and clears loaded.
      do_load(0, 1'b0, 1'b1);
      do_drain(30, -1);

      do_load(20, 1'b0, 1'b0);
      do_drain(0, 200);
      tick();
      do_load(10, 1'b0, 1'b0);
      do_drain(30, -1);

      repeat (3) tick();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
